// File: rtl/mxu_pkg.sv
// ============================================================================
// mxu_pkg : shared MXU widths, latencies and weight-loader state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mxu_pkg;

  localparam int MXU_DATA_W = 8;
  localparam int MXU_PSUM_W = 24;
  localparam int MXU_Y_W    = 8;
  localparam int MXU_PE_LAT = 3;

  typedef logic [1:0] wl_state_t;

  localparam wl_state_t WL_IDLE  = 2'd0;
  localparam wl_state_t WL_ISSUE = 2'd1;
  localparam wl_state_t WL_DRAIN = 2'd2;
  localparam wl_state_t WL_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mxu_weight_loader.sv
// ============================================================================
// mxu_weight_loader : streams ROWS weights into one MXU column preload chain,
// waits for the chain to drain, then pulses done. MXU_WL_CHECKSUM_EN adds
// the weight_sum output. Rev 1.0
// ============================================================================
`default_nettype none

module mxu_weight_loader
  import mxu_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int PE_LAT    = MXU_PE_LAT,
  parameter int DRAIN_CYC = ROWS * PE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [MXU_DATA_W-1:0] w_data,
  output logic                  load_phase,
  output logic [MXU_Y_W-1:0]    load_weight_target_y,
  output logic [MXU_DATA_W-1:0] load_weight
`ifdef MXU_WL_CHECKSUM_EN
  ,
  output logic [15:0]           weight_sum
`endif
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]   DRAIN_LOAD = CNT_W'(DRAIN_CYC);
  localparam logic [MXU_Y_W-1:0] IDX_LAST   = MXU_Y_W'(ROWS - 1);

  wl_state_t               state_q, state_d;
  logic [MXU_Y_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]        drain_q, drain_d;
  logic                    phase_q, phase_d;
  logic [MXU_Y_W-1:0]      tgt_q, tgt_d;
  logic [MXU_DATA_W-1:0]   wt_q, wt_d;
  logic                    w_hs;

  assign w_ready = (state_q == WL_ISSUE);
  assign busy    = (state_q != WL_IDLE);
  assign done    = (state_q == WL_DONE);
  assign w_hs    = w_ready && w_valid;

  assign load_phase           = phase_q;
  assign load_weight_target_y = tgt_q;
  assign load_weight          = wt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    phase_d = 1'b0;
    tgt_d   = '0;
    wt_d    = '0;
    case (state_q)
      WL_IDLE: begin
        if (start) begin
          state_d = WL_ISSUE;
          idx_d   = '0;
        end
      end
      WL_ISSUE: begin
        if (w_hs) begin
          phase_d = 1'b1;
          tgt_d   = idx_q;
          wt_d    = w_data;
          if (idx_q == IDX_LAST) begin
            drain_d = DRAIN_LOAD;
            state_d = (DRAIN_CYC == 0) ? WL_DONE : WL_DRAIN;
          end else begin
            idx_d = idx_q + MXU_Y_W'(1);
          end
        end
      end
      WL_DRAIN: begin
        // Leave on the cycle the counter reads 1; the <= also guards a stray 0.
        if (drain_q <= CNT_W'(1)) begin
          state_d = WL_DONE;
          drain_d = '0;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end
      WL_DONE: begin
        state_d = WL_IDLE;
      end
      default: begin
        state_d = WL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WL_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      phase_q <= 1'b0;
      tgt_q   <= '0;
      wt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      phase_q <= phase_d;
      tgt_q   <= tgt_d;
      wt_q    <= wt_d;
    end
  end

`ifdef MXU_WL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  assign weight_sum = sum_q;

  always_comb begin
    sum_d = sum_q;
    if ((state_q == WL_IDLE) && start) begin
      sum_d = '0;
    end else if (w_hs) begin
      sum_d = sum_q + {8'd0, w_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

endmodule

`default_nettype wire
